// File: rtl/dma_channel_regfile.sv
// Register file for a multi-channel DMA controller: per-channel base/current address and count, modes, status, byte-serial CPU access.
// Optional autoinit reload on terminal count is compiled in when DMA_REGFILE_AUTOINIT_EN is defined.
module dma_channel_regfile #(
  parameter int NUM_CH = 4,
  parameter int AW     = 16,
  localparam int CHW   = $clog2(NUM_CH)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CS_N,
  input  logic                IOR_N,
  input  logic                IOW_N,
  input  logic [CHW+1:0]      A,
  input  logic [7:0]          DB_IN,
  output logic [7:0]          DB_OUT,
  output logic                DB_OE,
  input  logic                programCondition,
  input  logic                step,
  input  logic [CHW-1:0]      stepCh,
  output logic [AW-1:0]       curAddr,
  output logic                tcPulse,
  output logic [CHW-1:0]      tcCh,
  output logic [NUM_CH*8-1:0] modeOut
);

  localparam int NB  = AW / 8;
  localparam int BPW = (NB > 2) ? 2 : 1;

  logic [AW-1:0]     base_addr [NUM_CH];
  logic [AW-1:0]     base_cnt  [NUM_CH];
  logic [AW-1:0]     cur_addr  [NUM_CH];
  logic [AW-1:0]     cur_cnt   [NUM_CH];
  logic [7:0]        mode      [NUM_CH];
  logic [7:0]        command;
  logic [NUM_CH-1:0] tc;
  logic [BPW-1:0]    bp;
  logic              iow_prev;
  logic              ior_prev;

  logic              access;
  logic              wr_fire;
  logic              rd_fire;
  logic [CHW:0]      offset;
  logic [CHW-1:0]    sel_ch;
  logic [CHW-1:0]    mode_ch;
  logic              sel_valid;
  logic              mode_valid;
  logic              chan_wr;
  logic              chan_rd;
  logic              cmd_wr;
  logic              stat_rd;
  logic              mode_wr;
  logic              clr_bp;
  logic              mclr;
  logic              step_valid;
  logic              step_tc;
  logic [NUM_CH-1:0] tc_set;
  logic [BPW-1:0]    bp_next;
  logic [AW-1:0]     rd_word;

  // Strobes act only on their falling edge, seen against last cycle's level.
  assign access  = programCondition & ~CS_N;
  assign wr_fire = access & ~IOW_N & iow_prev;
  assign rd_fire = access & ~IOR_N & ior_prev;

  assign offset     = A[CHW:0];
  assign sel_ch     = A[CHW:1];
  assign mode_ch    = DB_IN[CHW-1:0];
  assign sel_valid  = 32'(sel_ch) < NUM_CH;
  assign mode_valid = 32'(mode_ch) < NUM_CH;

  assign chan_wr = wr_fire & ~A[CHW+1] & sel_valid;
  assign chan_rd = rd_fire & ~A[CHW+1] & sel_valid;
  assign cmd_wr  = wr_fire & A[CHW+1] & (offset == (CHW+1)'(0));
  assign stat_rd = rd_fire & A[CHW+1] & (offset == (CHW+1)'(0));
  assign mode_wr = wr_fire & A[CHW+1] & (offset == (CHW+1)'(1)) & mode_valid;
  assign clr_bp  = wr_fire & A[CHW+1] & (offset == (CHW+1)'(2));
  assign mclr    = wr_fire & A[CHW+1] & (offset == (CHW+1)'(3));

  // A CPU write to the stepping channel takes the whole cycle; the step is dropped.
  assign step_valid = step & (32'(stepCh) < NUM_CH) & ~(chan_wr & (sel_ch == stepCh));
  assign step_tc    = step_valid & (cur_cnt[stepCh] == '0);
  assign tc_set     = step_tc ? (NUM_CH'(1) << stepCh) : '0;

  assign bp_next = (32'(bp) == NB - 1) ? '0 : bp + 1'b1;
  assign DB_OE   = ~CS_N & ~IOR_N & programCondition;

  always_comb begin
    rd_word = '0;
    curAddr = '0;
    if (sel_valid) rd_word = A[0] ? cur_cnt[sel_ch] : cur_addr[sel_ch];
    if (32'(stepCh) < NUM_CH) curAddr = cur_addr[stepCh];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_mode
    assign modeOut[i*8 +: 8] = mode[i];
  end

  always_ff @(posedge CLK) begin
    if (RESET || mclr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        base_cnt[i]  <= '0;
        cur_addr[i]  <= '0;
        cur_cnt[i]   <= '0;
        mode[i]      <= '0;
      end
      command  <= '0;
      tc       <= '0;
      bp       <= '0;
      DB_OUT   <= '0;
      tcPulse  <= 1'b0;
      tcCh     <= '0;
      iow_prev <= 1'b1;
      ior_prev <= 1'b1;
    end else begin
      iow_prev <= IOW_N;
      ior_prev <= IOR_N;
      tcPulse  <= step_tc;
      if (step_tc) tcCh <= stepCh;
      // A terminal count arriving with a status read survives the clear.
      tc <= (stat_rd ? '0 : tc) | tc_set;

      if (step_valid) begin
`ifdef DMA_REGFILE_AUTOINIT_EN
        if (step_tc && mode[stepCh][3]) begin
          cur_addr[stepCh] <= base_addr[stepCh];
          cur_cnt[stepCh]  <= base_cnt[stepCh];
        end else
`endif
        begin
          cur_addr[stepCh] <= mode[stepCh][4] ? cur_addr[stepCh] - 1'b1 : cur_addr[stepCh] + 1'b1;
          cur_cnt[stepCh]  <= cur_cnt[stepCh] - 1'b1;
        end
      end

      if (chan_wr) begin
        if (A[0]) begin
          base_cnt[sel_ch][{bp, 3'b000} +: 8] <= DB_IN;
          cur_cnt[sel_ch][{bp, 3'b000} +: 8]  <= DB_IN;
        end else begin
          base_addr[sel_ch][{bp, 3'b000} +: 8] <= DB_IN;
          cur_addr[sel_ch][{bp, 3'b000} +: 8]  <= DB_IN;
        end
      end

      if (mode_wr) mode[mode_ch] <= {DB_IN[7:3], 3'b000};
      if (cmd_wr) command <= DB_IN;

      if (clr_bp) bp <= '0;
      else if (chan_wr || chan_rd) bp <= bp_next;

      if (chan_rd) DB_OUT <= rd_word[{bp, 3'b000} +: 8];
      else if (stat_rd) DB_OUT <= 8'(tc);
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Self-checking bench for dma_channel_regfile: directed table, corner sequences and randomized traffic against a byte-level model.
// Expected values follow DMA_REGFILE_AUTOINIT_EN when it is defined.
module tb_dma_channel_regfile;
  localparam int NUM_CH = 4;
  localparam int AW     = 16;
  localparam int NB     = AW / 8;

`ifdef DMA_REGFILE_AUTOINIT_EN
  localparam logic [15:0] AI_ADDR = 16'h0100;
  localparam logic [15:0] AI_CNT  = 16'h0000;
`else
  localparam logic [15:0] AI_ADDR = 16'h0101;
  localparam logic [15:0] AI_CNT  = 16'hFFFF;
`endif

  logic        CLK = 1'b0;
  logic        RESET, CS_N, IOR_N, IOW_N, programCondition, step;
  logic [3:0]  A;
  logic [7:0]  DB_IN, DB_OUT;
  logic        DB_OE, tcPulse;
  logic [1:0]  stepCh, tcCh;
  logic [15:0] curAddr;
  logic [31:0] modeOut;

  logic        cs_n_w, ior_n_w, iow_n_w, step_w, db_oe_w, tc_pulse_w;
  logic [3:0]  a_w;
  logic [7:0]  db_in_w, db_out_w;
  logic [1:0]  step_ch_w, tc_ch_w;
  logic [23:0] cur_addr_w;
  logic [31:0] mode_out_w;

  dma_channel_regfile #(.NUM_CH(NUM_CH), .AW(AW)) u_dut (
    .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .programCondition(programCondition),
    .step(step), .stepCh(stepCh), .curAddr(curAddr), .tcPulse(tcPulse), .tcCh(tcCh),
    .modeOut(modeOut)
  );

  dma_channel_regfile #(.NUM_CH(4), .AW(24)) u_dut_w (
    .CLK(CLK), .RESET(RESET), .CS_N(cs_n_w), .IOR_N(ior_n_w), .IOW_N(iow_n_w), .A(a_w),
    .DB_IN(db_in_w), .DB_OUT(db_out_w), .DB_OE(db_oe_w), .programCondition(1'b1),
    .step(step_w), .stepCh(step_ch_w), .curAddr(cur_addr_w), .tcPulse(tc_pulse_w), .tcCh(tc_ch_w),
    .modeOut(mode_out_w)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: registers as plain integers, bytes inserted/extracted arithmetically.
  int unsigned m_base_addr [NUM_CH];
  int unsigned m_base_cnt  [NUM_CH];
  int unsigned m_cur_addr  [NUM_CH];
  int unsigned m_cur_cnt   [NUM_CH];
  int unsigned m_mode      [NUM_CH];
  int unsigned m_tc;
  int          m_bp;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_base_addr[i] = 0; m_base_cnt[i] = 0; m_cur_addr[i] = 0; m_cur_cnt[i] = 0; m_mode[i] = 0;
    end
    m_tc = 0;
    m_bp = 0;
  endfunction

  function automatic int unsigned put_byte(int unsigned word, int idx, int unsigned b);
    return (word & ~(32'hFF << (8 * idx))) | ((b & 32'hFF) << (8 * idx));
  endfunction

  function automatic void model_write(int unsigned a, int unsigned d);
    int unsigned ch;
    if (a < 8) begin
      ch = a / 2;
      if (a % 2 == 1) begin
        m_base_cnt[ch] = put_byte(m_base_cnt[ch], m_bp, d);
        m_cur_cnt[ch]  = put_byte(m_cur_cnt[ch], m_bp, d);
      end else begin
        m_base_addr[ch] = put_byte(m_base_addr[ch], m_bp, d);
        m_cur_addr[ch]  = put_byte(m_cur_addr[ch], m_bp, d);
      end
      m_bp = (m_bp + 1) % NB;
    end else begin
      case (a - 8)
        1: m_mode[d % NUM_CH] = d & 32'hF8;
        2: m_bp = 0;
        3: model_reset();
        default: ;
      endcase
    end
  endfunction

  function automatic int unsigned model_read(int unsigned a);
    int unsigned r;
    if (a < 8) begin
      r = (((a % 2 == 1) ? m_cur_cnt[a / 2] : m_cur_addr[a / 2]) >> (8 * m_bp)) & 32'hFF;
      m_bp = (m_bp + 1) % NB;
    end else begin
      r = m_tc;
      m_tc = 0;
    end
    return r;
  endfunction

  function automatic bit model_step(int c);
    bit hit;
    hit = (m_cur_cnt[c] == 0);
    if (hit) m_tc = m_tc | (32'd1 << c);
`ifdef DMA_REGFILE_AUTOINIT_EN
    if (hit && (m_mode[c] & 32'h08) != 0) begin
      m_cur_addr[c] = m_base_addr[c];
      m_cur_cnt[c]  = m_base_cnt[c];
      return hit;
    end
`endif
    if ((m_mode[c] & 32'h10) != 0) m_cur_addr[c] = (m_cur_addr[c] - 1) & 32'hFFFF;
    else m_cur_addr[c] = (m_cur_addr[c] + 1) & 32'hFFFF;
    m_cur_cnt[c] = (m_cur_cnt[c] - 1) & 32'hFFFF;
    return hit;
  endfunction

  function automatic logic [31:0] model_mode_flat();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i*8 +: 8] = 8'(m_mode[i]);
    return r;
  endfunction

  logic [7:0]  s_db_out;
  logic        s_db_oe, s_tc_pulse, s_tc_after;
  logic [1:0]  s_tc_ch;
  logic [15:0] s_cur_addr;

  // One strobe cycle plus one idle cycle; called and returns at a falling edge.
  task automatic bus_cycle(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d,
                           input bit stp, input logic [1:0] sc);
    A = a; DB_IN = d; CS_N = !(wr || rd); IOW_N = !wr; IOR_N = !rd; step = stp; stepCh = sc;
    @(negedge CLK);
    s_db_out = DB_OUT; s_db_oe = DB_OE; s_tc_pulse = tcPulse; s_tc_ch = tcCh; s_cur_addr = curAddr;
    CS_N = 1'b1; IOW_N = 1'b1; IOR_N = 1'b1; step = 1'b0;
    @(negedge CLK);
    s_tc_after = tcPulse;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    model_write(32'(a), 32'(d));
    bus_cycle(1'b1, 1'b0, a, d, 1'b0, 2'd0);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] got);
    int unsigned exp;
    exp = model_read(32'(a));
    bus_cycle(1'b0, 1'b1, a, 8'h00, 1'b0, 2'd0);
    got = s_db_out;
    check("read_db_out", 32'(s_db_out), exp);
    check("read_db_oe", 32'(s_db_oe), 32'd1);
  endtask

  task automatic read_word(input logic [3:0] a, output logic [15:0] w);
    logic [7:0] lo, hi;
    do_read(a, lo);
    do_read(a, hi);
    w = {hi, lo};
  endtask

  task automatic do_step(input logic [1:0] c, output logic pulse);
    bit exp_tc;
    exp_tc = model_step(int'(c));
    bus_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, c);
    pulse = s_tc_pulse;
    check("step_tc_pulse", 32'(s_tc_pulse), 32'(exp_tc));
    if (exp_tc) check("step_tc_ch", 32'(s_tc_ch), 32'(c));
    check("step_cur_addr", 32'(s_cur_addr), m_cur_addr[c]);
    check("step_pulse_width", 32'(s_tc_after), 32'd0);
  endtask

  task automatic bus_w(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d);
    a_w = a; db_in_w = d; cs_n_w = 1'b0; iow_n_w = !wr; ior_n_w = !rd;
    @(negedge CLK);
    cs_n_w = 1'b1; iow_n_w = 1'b1; ior_n_w = 1'b1;
    @(negedge CLK);
  endtask

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t table_v [16];

  initial begin
    logic [7:0]  rb;
    logic [15:0] w;
    logic        p;
    int unsigned kind;
    logic [3:0]  ra;
    logic [7:0]  rd;

    table_v[0]  = '{1'b1, 4'b0010, 8'h34, 8'h00};
    table_v[1]  = '{1'b1, 4'b0010, 8'h12, 8'h00};
    table_v[2]  = '{1'b0, 4'b0010, 8'h00, 8'h34};
    table_v[3]  = '{1'b0, 4'b0010, 8'h00, 8'h12};
    table_v[4]  = '{1'b1, 4'b0101, 8'h02, 8'h00};
    table_v[5]  = '{1'b1, 4'b0101, 8'h00, 8'h00};
    table_v[6]  = '{1'b0, 4'b0101, 8'h00, 8'h02};
    table_v[7]  = '{1'b0, 4'b0101, 8'h00, 8'h00};
    table_v[8]  = '{1'b1, 4'b0110, 8'h00, 8'h00};
    table_v[9]  = '{1'b1, 4'b0110, 8'h00, 8'h00};
    table_v[10] = '{1'b1, 4'b1001, 8'h13, 8'h00};
    table_v[11] = '{1'b1, 4'b0001, 8'h77, 8'h00};
    table_v[12] = '{1'b1, 4'b1010, 8'h00, 8'h00};
    table_v[13] = '{1'b0, 4'b0001, 8'h00, 8'h77};
    table_v[14] = '{1'b0, 4'b0001, 8'h00, 8'h00};
    table_v[15] = '{1'b0, 4'b1000, 8'h00, 8'h00};

    RESET = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; programCondition = 1'b1;
    step = 1'b0; stepCh = 2'd0; A = 4'h0; DB_IN = 8'h00;
    cs_n_w = 1'b1; ior_n_w = 1'b1; iow_n_w = 1'b1; step_w = 1'b0; step_ch_w = 2'd0;
    a_w = 4'h0; db_in_w = 8'h00;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_db_out", 32'(DB_OUT), 32'h0);
    check("reset_tc_pulse", 32'(tcPulse), 32'h0);
    check("reset_mode_out", modeOut, 32'h0);
    check("reset_cur_addr", 32'(curAddr), 32'h0);
    check("reset_db_oe", 32'(DB_OE), 32'h0);
    check("reset_db_out_w", 32'(db_out_w), 32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    $display("[TB] directed table");
    for (int i = 0; i < 16; i++) begin
      if (table_v[i].wr) begin
        do_write(table_v[i].a, table_v[i].d);
      end else begin
        do_read(table_v[i].a, rb);
        check("table_read", 32'(rb), 32'(table_v[i].exp));
      end
    end
    check("table_mode_out", modeOut, 32'h1000_0000);

    $display("[TB] terminal count on channel 2");
    do_step(2'd2, p);
    check("tc_step1_pulse", 32'(p), 32'd0);
    read_word(4'b0101, w);
    check("tc_step1_count", 32'(w), 32'h0001);
    do_step(2'd2, p);
    check("tc_step2_pulse", 32'(p), 32'd0);
    read_word(4'b0101, w);
    check("tc_step2_count", 32'(w), 32'h0000);
    do_step(2'd2, p);
    check("tc_step3_pulse", 32'(p), 32'd1);
    check("tc_step3_ch", 32'(s_tc_ch), 32'd2);
    read_word(4'b0101, w);
    check("tc_step3_count", 32'(w), 32'hFFFF);
    do_read(4'b1000, rb);
    check("status_first", 32'(rb), 32'h04);
    do_read(4'b1000, rb);
    check("status_second", 32'(rb), 32'h00);

    $display("[TB] decrement wrap on channel 3");
    do_step(2'd3, p);
    check("dec_wrap_addr", 32'(s_cur_addr), 32'hFFFF);
    do_read(4'b1000, rb);
    check("dec_status", 32'(rb), 32'h08);

    $display("[TB] autoinit on channel 0");
    do_write(4'b1010, 8'h00);
    do_write(4'b1001, 8'h08);
    do_write(4'b0000, 8'h00);
    do_write(4'b0000, 8'h01);
    do_write(4'b0001, 8'h00);
    do_write(4'b0001, 8'h00);
    check("autoinit_mode_out", modeOut, 32'h1000_0008);
    do_step(2'd0, p);
    check("autoinit_pulse", 32'(p), 32'd1);
    check("autoinit_addr", 32'(s_cur_addr), 32'(AI_ADDR));
    read_word(4'b0001, w);
    check("autoinit_count", 32'(w), 32'(AI_CNT));
    do_read(4'b1000, rb);
    check("autoinit_status", 32'(rb), 32'h01);

    $display("[TB] held write strobe");
    do_write(4'b1010, 8'h00);
    model_write(32'b0010, 32'h55);
    A = 4'b0010; DB_IN = 8'h55; CS_N = 1'b0; IOW_N = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge CLK);
      DB_IN = 8'(8'h55 + k * 8'h11);
    end
    @(negedge CLK);
    CS_N = 1'b1; IOW_N = 1'b1;
    @(negedge CLK);
    do_read(4'b0010, rb);
    check("held_write_hi", 32'(rb), 32'h12);
    do_read(4'b0010, rb);
    check("held_write_lo", 32'(rb), 32'h55);

    $display("[TB] write and step collide on channel 1");
    do_write(4'b1010, 8'h00);
    model_write(32'b0011, 32'hA5);
    bus_cycle(1'b1, 1'b0, 4'b0011, 8'hA5, 1'b1, 2'd1);
    check("collide_pulse", 32'(s_tc_pulse), 32'd0);
    check("collide_addr", 32'(s_cur_addr), 32'h1255);
    do_write(4'b0011, 8'h00);
    read_word(4'b0011, w);
    check("collide_count", 32'(w), 32'h00A5);

    $display("[TB] status clear against tc set");
    do_write(4'b1010, 8'h00);
    do_write(4'b0101, 8'h00);
    do_write(4'b0101, 8'h00);
    begin
      int unsigned exp_db;
      bit exp_p;
      exp_db = model_read(32'b1000);
      exp_p  = model_step(2);
      bus_cycle(1'b0, 1'b1, 4'b1000, 8'h00, 1'b1, 2'd2);
      check("race_db_out", 32'(s_db_out), exp_db);
      check("race_pulse", 32'(s_tc_pulse), 32'(exp_p));
    end
    do_read(4'b1000, rb);
    check("race_status", 32'(rb), 32'h04);

    $display("[TB] master clear");
    do_write(4'b1011, 8'h00);
    check("mclr_mode_out", modeOut, 32'h0);
    do_read(4'b1000, rb);
    check("mclr_status", 32'(rb), 32'h00);
    read_word(4'b0010, w);
    check("mclr_addr", 32'(w), 32'h0000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      rd   = 8'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      if (kind <= 3) begin
        do_write(ra, rd);
      end else if (kind <= 5) begin
        do_read(4'($urandom_range(0, 7)), rb);
      end else if (kind == 6) begin
        do_read(4'b1000, rb);
      end else if (kind <= 8) begin
        do_step(2'($urandom_range(0, 3)), p);
      end else begin
        programCondition = 1'b0;
        bus_cycle(1'b1, 1'b0, ra, rd, 1'b0, 2'd0);
        programCondition = 1'b1;
      end
      if (n % 16 == 15) check("rand_mode_out", modeOut, model_mode_flat());
    end

    $display("[TB] reset in the middle of a byte pair");
    do_write(4'b1010, 8'h00);
    do_write(4'b0000, 8'hAB);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    do_write(4'b0000, 8'hCD);
    do_write(4'b0000, 8'hEF);
    read_word(4'b0000, w);
    check("reset_mid_word", 32'(w), 32'hEFCD);

    $display("[TB] 24-bit address width");
    bus_w(1'b1, 1'b0, 4'b0000, 8'h56);
    bus_w(1'b1, 1'b0, 4'b0000, 8'h34);
    bus_w(1'b1, 1'b0, 4'b0000, 8'h12);
    check("w24_cur_addr", 32'(cur_addr_w), 32'h123456);
    bus_w(1'b1, 1'b0, 4'b1010, 8'h00);
    bus_w(1'b0, 1'b1, 4'b0000, 8'h00);
    check("w24_read0", 32'(db_out_w), 32'h56);
    bus_w(1'b0, 1'b1, 4'b0000, 8'h00);
    check("w24_read1", 32'(db_out_w), 32'h34);
    bus_w(1'b0, 1'b1, 4'b0000, 8'h00);
    check("w24_read2", 32'(db_out_w), 32'h12);
    bus_w(1'b0, 1'b1, 4'b0000, 8'h00);
    check("w24_read_wrap", 32'(db_out_w), 32'h56);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_channel_regfile.md
DMA_CHANNEL_REGFILE -- requirements
Module: dma_channel_regfile

Interface
REQ-001 Parameter NUM_CH, default 4: channel count, legal 2..8; CHW = clog2(NUM_CH).
REQ-002 Parameter AW, default 16: address and word-count width, multiple of 8, legal 16..32; NB = AW/8 bytes per register.
REQ-003 Port CLK  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port RESET  in  1: reset, synchronous and active-high.
REQ-005 Ports CS_N, IOR_N, IOW_N  in  1 each: chip select, read strobe and write strobe, all active-low.
REQ-006 Port A  in  CHW+2: register address.
REQ-007 Port DB_IN  in  8: CPU write data.
REQ-008 Port DB_OUT  out  8: registered CPU read data.
REQ-009 Port DB_OE  out  1: read-data enable.
REQ-010 Port programCondition  in  1: CPU programming allowed.
REQ-011 Ports step  in  1 and stepCh  in  CHW: one-cycle strobe that completes one transfer on channel stepCh.
REQ-012 Port curAddr  out  AW: current address of channel stepCh, combinational.
REQ-013 Ports tcPulse  out  1 and tcCh  out  CHW: terminal-count indication.
REQ-014 Port modeOut  out  NUM_CH*8: all channel mode registers, flattened.

Function
REQ-015 Access decode:
- A CPU access exists only when programCondition=1 and CS_N=0.
- A write fires once, on the first cycle IOW_N is low after being high, using a registered previous value of IOW_N.
- A read fires the same way on IOR_N.
- Holding a strobe low produces no repeat access.
REQ-016 Address map:
- A[CHW+1]=0: channel register; A[CHW:1] selects the channel; A[0]=0 is address, A[0]=1 is word count.
- A[CHW+1]=1 and A[CHW:0]=0: write = command register, read = status register.
- A[CHW:0]=1: mode write. A[CHW:0]=2: clear byte pointer. A[CHW:0]=3: master clear.
- Any other offset is ignored.
REQ-017 A channel-register write stores DB_IN into byte[bp] of both the base and current copies; bp then increments, wrapping from NB-1 to 0.
REQ-018 A channel-register read loads byte[bp] of the current copy into DB_OUT one cycle after the read fires; bp then increments with the same wrap.
REQ-019 DB_OE = !CS_N & !IOR_N & programCondition.
REQ-020 Mode write: DB_IN[CHW-1:0] selects the channel; the mode byte stored is {DB_IN[7:3], 3'b000}. Bit 3 = autoinit, bit 4 = decrement.
REQ-021 Status read returns the TC bits in [NUM_CH-1:0] and zeros above, then clears all TC bits on the next edge.
REQ-022 Step on channel c:
- Current address becomes address+1, or address-1 when decrement is set, modulo 2^AW.
- Word count decrements modulo 2^AW.
REQ-023 If the word count is 0 before a step:
- tcPulse=1 and tcCh=c for exactly the next cycle.
- Status TC bit c is set.
- The word count wraps to all-ones.
REQ-024 A CPU write to channel c in the same cycle as a step on c: the CPU write wins, and the step is discarded with no TC.
REQ-025 A TC set and a status read clear in the same cycle: the set wins.
REQ-026 Master clear has the same effect as RESET on all state.

Reset
REQ-027 On RESET=1 at a clock edge:
- All base, current and mode registers, command, status and bp go to 0.
- DB_OUT=0 and tcPulse=0.
- Strobe history registers go to 1.
REQ-028 RESET during a multi-byte sequence abandons it; the next access uses byte 0.

Configuration
REQ-029 Macro DMA_REGFILE_AUTOINIT_EN defined: on a TC step with autoinit=1, the current address and count reload from the base copies instead of stepping or wrapping.
REQ-030 Macro DMA_REGFILE_AUTOINIT_EN undefined: mode bit 3 is stored but has no effect, and there is no reload logic.

Verification
REQ-031 NUM_CH=4, AW=16: write 0x34 then 0x12 to A=0b0010 -> channel 1 base and current address = 0x1234, bp=0.
REQ-032 Count=0x0002 on ch2, three steps -> counts 1, 0, 0xFFFF; tcPulse on the 3rd step only; status read = 0x04, then a second read = 0x00.
REQ-033 Decrement mode, address 0x0000, one step -> address 0xFFFF.
REQ-034 With the macro defined: autoinit, base 0x0100, count 0; one step -> current address 0x0100 and count 0, tcPulse=1. Without the macro -> address 0x0101 and count 0xFFFF.
REQ-035 IOW_N held low for 5 cycles with one write -> exactly one byte stored and bp advances once; write and step on the same channel in the same cycle -> CPU value kept.
REQ-036 AW=24: three byte writes of 0x56, 0x34, 0x12, then clear byte pointer and three reads -> DB_OUT returns 0x56, 0x34, 0x12.
